dpc_sequencer: RTL and testbench

Parametrised control sequencer for the DekatronPC core: drives the IP line (fetch/loop-skip) and AP line (pointer/data ops), arbitrates `IO_CH` console channels, and adds run-for-N-steps, an IP breakpoint, console-I/O timeout and a latched halt-reason code on top of the existing fetch/exec control flow. It sits between the front panel (Halt/Step/Run) and the IpLine/ApLine blocks.

---
 rtl/dpc_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_dpc_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpc_sequencer.sv
// dpc_sequencer: control sequencer for the DekatronPC core.
// Sits between the front panel (Halt/Step/Run) and the IpLine/ApLine blocks. It fetches over the
// IP line, executes over the AP line, arbitrates IO_CH console channels, and supports
// run-for-N-steps, an IP breakpoint, a console-I/O timeout and a latched halt-reason code.
//
// Ports:
//   Clk, Rst_n             clock, asynchronous active-low reset
//   Halt, Step, Run        front-panel controls
//   StepCount              instructions per Step (0 treated as 1)
//   BrkEn, BrkAddr         IP breakpoint enable and address
//   IpRequest/IpReady      IP line handshake; IpAddress/Insn are valid with IpReady
//   ApRequest, DataRequest, Dec, Zero, Cin / ApReady, ApZero, DataZero   AP line
//   Cout, CinReq / CioAcq  per-channel console handshake
//   ChSel                  active console channel
//   Mode                   1 = brainfuck ISA, 0 = debug ISA
//   state                  IDLE=1 FETCH=2 EXEC=3 HALT=4 CIN=5 COUT=6
//   HaltReason             0 reset, 1 Halt, 2 steps done, 3 HALT opcode, 4 breakpoint, 5 timeout
//   Iret                   retired-instruction count (wraps)
module dpc_sequencer #(
    parameter int unsigned INSN_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned IO_CH       = 2,
    parameter int unsigned IRET_WIDTH  = 32,
    parameter int unsigned STEP_WIDTH  = 8,
    parameter int unsigned CIO_TIMEOUT = 0,
    localparam int unsigned ChW        = (IO_CH > 1) ? $clog2(IO_CH) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Halt,
    input  logic                  Step,
    input  logic                  Run,
    input  logic [STEP_WIDTH-1:0] StepCount,
    input  logic                  BrkEn,
    input  logic [ADDR_WIDTH-1:0] BrkAddr,
    output logic                  IpRequest,
    input  logic                  IpReady,
    input  logic [ADDR_WIDTH-1:0] IpAddress,
    input  logic [INSN_WIDTH-1:0] Insn,
    output logic                  ApRequest,
    output logic                  DataRequest,
    output logic                  Dec,
    output logic                  Zero,
    output logic                  Cin,
    input  logic                  ApReady,
    input  logic                  ApZero,
    input  logic                  DataZero,
    output logic [IO_CH-1:0]      Cout,
    output logic [IO_CH-1:0]      CinReq,
    input  logic [IO_CH-1:0]      CioAcq,
    output logic [ChW-1:0]        ChSel,
    output logic                  Mode,
    output logic [2:0]            state,
    output logic [2:0]            HaltReason,
    output logic [IRET_WIDTH-1:0] Iret
);

    localparam int unsigned CntW = (CIO_TIMEOUT > 1) ? $clog2(CIO_TIMEOUT) : 1;
    localparam logic [CntW-1:0] ToLast = CntW'((CIO_TIMEOUT == 0) ? 0 : CIO_TIMEOUT - 1);

    localparam logic [INSN_WIDTH-1:0] OpNop    = INSN_WIDTH'(4'h0);
    localparam logic [INSN_WIDTH-1:0] OpHalt   = INSN_WIDTH'(4'h1);
    localparam logic [INSN_WIDTH-1:0] OpInc    = INSN_WIDTH'(4'h2);
    localparam logic [INSN_WIDTH-1:0] OpDec    = INSN_WIDTH'(4'h3);
    localparam logic [INSN_WIDTH-1:0] OpApInc  = INSN_WIDTH'(4'h4);
    localparam logic [INSN_WIDTH-1:0] OpApDec  = INSN_WIDTH'(4'h5);
    localparam logic [INSN_WIDTH-1:0] OpLoopZ  = INSN_WIDTH'(4'h6);
    localparam logic [INSN_WIDTH-1:0] OpLoopNz = INSN_WIDTH'(4'h7);
    localparam logic [INSN_WIDTH-1:0] OpCout   = INSN_WIDTH'(4'h8);
    localparam logic [INSN_WIDTH-1:0] OpCin    = INSN_WIDTH'(4'h9);
    localparam logic [INSN_WIDTH-1:0] OpClrD   = INSN_WIDTH'(4'hA);
    localparam logic [INSN_WIDTH-1:0] OpClrAp  = INSN_WIDTH'(4'hB);
    localparam logic [INSN_WIDTH-1:0] OpNextCh = INSN_WIDTH'(4'hC);
    localparam logic [INSN_WIDTH-1:0] OpDbg    = INSN_WIDTH'(4'hE);
    localparam logic [INSN_WIDTH-1:0] OpBf     = INSN_WIDTH'(4'hF);

    localparam logic [2:0] RsnHalt    = 3'd1;
    localparam logic [2:0] RsnSteps   = 3'd2;
    localparam logic [2:0] RsnOpcode  = 3'd3;
    localparam logic [2:0] RsnBrk     = 3'd4;
    localparam logic [2:0] RsnTimeout = 3'd5;

    typedef enum logic [2:0] {
        StIdle  = 3'd1,
        StFetch = 3'd2,
        StExec  = 3'd3,
        StHalt  = 3'd4,
        StCin   = 3'd5,
        StCout  = 3'd6
    } state_e;

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [ChW-1:0]          ch_sel_q, ch_sel_d;
    logic [IRET_WIDTH-1:0]   iret_q, iret_d;
    logic [2:0]              halt_reason_q, halt_reason_d;
    logic                    ip_request_q, ip_request_d;
    logic                    ap_request_q, ap_request_d;
    logic                    data_request_q, data_request_d;
    logic                    dec_q, dec_d;
    logic                    zero_q, zero_d;
    logic                    cin_q, cin_d;
    logic [IO_CH-1:0]        cout_q, cout_d;
    logic [IO_CH-1:0]        cin_req_q, cin_req_d;
    logic [STEP_WIDTH-1:0]   step_left_q, step_left_d;
    logic [CntW-1:0]         to_cnt_q, to_cnt_d;
    logic                    brk_skip_q, brk_skip_d;
    logic                    loop_val_zero;
    logic                    timed_out;

    assign loop_val_zero = mode_q ? DataZero : ApZero;
    assign timed_out     = (CIO_TIMEOUT != 0) && (to_cnt_q == ToLast);

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        ch_sel_d       = ch_sel_q;
        iret_d         = iret_q;
        halt_reason_d  = halt_reason_q;
        ip_request_d   = 1'b0;
        ap_request_d   = 1'b0;
        data_request_d = 1'b0;
        dec_d          = dec_q;
        zero_d         = 1'b0;
        cin_d          = 1'b0;
        cout_d         = cout_q;
        cin_req_d      = cin_req_q;
        step_left_d    = step_left_q;
        to_cnt_d       = to_cnt_q;
        brk_skip_d     = brk_skip_q;

        case (state_q)
            StHalt: begin
                // BrkSkip lets a run resume from the instruction that hit the breakpoint.
                if (Step) begin
                    step_left_d  = (StepCount == '0) ? STEP_WIDTH'(1) : StepCount;
                    brk_skip_d   = 1'b1;
                    ip_request_d = 1'b1;
                    state_d      = StIdle;
                end else if (Run) begin
                    step_left_d  = '0;
                    brk_skip_d   = 1'b1;
                    ip_request_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            StIdle: state_d = StFetch;
            StFetch: begin
                if (IpReady) begin
                    if (BrkEn && (IpAddress == BrkAddr) && !brk_skip_q) begin
                        halt_reason_d = RsnBrk;
                        state_d       = StHalt;
                    end else begin
                        brk_skip_d = 1'b0;
                        state_d    = StExec;
                        case (Insn)
                            OpNop: ;
                            OpHalt: begin
                                halt_reason_d = RsnOpcode;
                                state_d       = StHalt;
                            end
                            // Loop skip: ask for the next word and keep fetching without retiring.
                            OpLoopZ: begin
                                if (loop_val_zero) begin
                                    ip_request_d = 1'b1;
                                    state_d      = StFetch;
                                end
                            end
                            OpLoopNz: begin
                                if (!loop_val_zero) begin
                                    ip_request_d = 1'b1;
                                    state_d      = StFetch;
                                end
                            end
                            OpClrD: begin
                                data_request_d = 1'b1;
                                zero_d         = 1'b1;
                            end
                            OpDbg: mode_d = 1'b0;
                            OpBf:  mode_d = 1'b1;
                            default: begin
                                if (mode_q) begin
                                    case (Insn)
                                        OpInc, OpDec: begin
                                            data_request_d = 1'b1;
                                            dec_d          = Insn[0];
                                        end
                                        OpApInc, OpApDec: begin
                                            ap_request_d = 1'b1;
                                            dec_d        = Insn[0];
                                        end
                                        OpCout: begin
                                            cout_d[ch_sel_q] = 1'b1;
                                            to_cnt_d         = '0;
                                            state_d          = StCout;
                                        end
                                        OpCin: begin
                                            cin_req_d[ch_sel_q] = 1'b1;
                                            to_cnt_d            = '0;
                                            state_d             = StCin;
                                        end
                                        default: ;
                                    endcase
                                end else begin
                                    case (Insn)
                                        OpClrAp: begin
                                            ap_request_d = 1'b1;
                                            zero_d       = 1'b1;
                                        end
                                        OpNextCh: begin
                                            ch_sel_d = (ch_sel_q == ChW'(IO_CH - 1)) ? '0
                                                                                    : ch_sel_q + 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        endcase
                    end
                end
            end
            // Ack is checked before the timeout so a same-cycle ack wins.
            StCout: begin
                if (CioAcq[ch_sel_q]) begin
                    cout_d  = '0;
                    state_d = StExec;
                end else if (timed_out) begin
                    cout_d        = '0;
                    halt_reason_d = RsnTimeout;
                    state_d       = StHalt;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StCin: begin
                if (CioAcq[ch_sel_q]) begin
                    cin_req_d      = '0;
                    data_request_d = 1'b1;
                    cin_d          = 1'b1;
                    state_d        = StExec;
                end else if (timed_out) begin
                    cin_req_d     = '0;
                    halt_reason_d = RsnTimeout;
                    state_d       = StHalt;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StExec: begin
                if (ApReady) begin
                    iret_d = iret_q + 1'b1;
                    if (step_left_q != '0) step_left_d = step_left_q - 1'b1;
                    if (Halt) begin
                        halt_reason_d = RsnHalt;
                        state_d       = StHalt;
                    end else if (step_left_q == STEP_WIDTH'(1)) begin
                        halt_reason_d = RsnSteps;
                        state_d       = StHalt;
                    end else begin
                        ip_request_d = 1'b1;
                        state_d      = StFetch;
                    end
                end
            end
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= StHalt;
            mode_q         <= 1'b1;
            ch_sel_q       <= '0;
            iret_q         <= '0;
            halt_reason_q  <= '0;
            ip_request_q   <= 1'b0;
            ap_request_q   <= 1'b0;
            data_request_q <= 1'b0;
            dec_q          <= 1'b0;
            zero_q         <= 1'b0;
            cin_q          <= 1'b0;
            cout_q         <= '0;
            cin_req_q      <= '0;
            step_left_q    <= '0;
            to_cnt_q       <= '0;
            brk_skip_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            ch_sel_q       <= ch_sel_d;
            iret_q         <= iret_d;
            halt_reason_q  <= halt_reason_d;
            ip_request_q   <= ip_request_d;
            ap_request_q   <= ap_request_d;
            data_request_q <= data_request_d;
            dec_q          <= dec_d;
            zero_q         <= zero_d;
            cin_q          <= cin_d;
            cout_q         <= cout_d;
            cin_req_q      <= cin_req_d;
            step_left_q    <= step_left_d;
            to_cnt_q       <= to_cnt_d;
            brk_skip_q     <= brk_skip_d;
        end
    end

    assign state       = state_q;
    assign Mode        = mode_q;
    assign ChSel       = ch_sel_q;
    assign Iret        = iret_q;
    assign HaltReason  = halt_reason_q;
    assign IpRequest   = ip_request_q;
    assign ApRequest   = ap_request_q;
    assign DataRequest = data_request_q;
    assign Dec         = dec_q;
    assign Zero        = zero_q;
    assign Cin         = cin_q;
    assign Cout        = cout_q;
    assign CinReq      = cin_req_q;

endmodule

// File: tb/tb_dpc_sequencer.sv
// Directed bench for dpc_sequencer (IO_CH=2, CIO_TIMEOUT=10). A small IP-line model inside the
// tick task answers each IpRequest with one IpReady pulse carrying the next ROM word.
module tb_dpc_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Halt = 1'b0, Step = 1'b0, Run = 1'b0;
    logic [7:0]  StepCount = 8'd0;
    logic        BrkEn = 1'b0;
    logic [23:0] BrkAddr = 24'd0;
    logic        IpRequest, IpReady = 1'b0;
    logic [23:0] IpAddress = 24'd0;
    logic [3:0]  Insn = 4'd0;
    logic        ApRequest, DataRequest, Dec, Zero, Cin;
    logic        ApReady = 1'b1, ApZero = 1'b0, DataZero = 1'b0;
    logic [1:0]  Cout, CinReq, CioAcq = 2'b00;
    logic [0:0]  ChSel;
    logic        Mode;
    logic [2:0]  state, HaltReason;
    logic [31:0] Iret;

    int   n_cmp = 0, n_fail = 0;
    int   pc = 0, req_cnt = 0, dreq_cnt = 0, apreq_cnt = 0, cinreq_cyc = 0;
    logic ip_pend = 1'b0;
    logic dec_seen = 1'b0;
    logic [3:0] rom [64];

    always #5 Clk = ~Clk;

    dpc_sequencer #(
        .INSN_WIDTH (4),
        .ADDR_WIDTH (24),
        .IO_CH      (2),
        .IRET_WIDTH (32),
        .STEP_WIDTH (8),
        .CIO_TIMEOUT(10)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Halt       (Halt),
        .Step       (Step),
        .Run        (Run),
        .StepCount  (StepCount),
        .BrkEn      (BrkEn),
        .BrkAddr    (BrkAddr),
        .IpRequest  (IpRequest),
        .IpReady    (IpReady),
        .IpAddress  (IpAddress),
        .Insn       (Insn),
        .ApRequest  (ApRequest),
        .DataRequest(DataRequest),
        .Dec        (Dec),
        .Zero       (Zero),
        .Cin        (Cin),
        .ApReady    (ApReady),
        .ApZero     (ApZero),
        .DataZero   (DataZero),
        .Cout       (Cout),
        .CinReq     (CinReq),
        .CioAcq     (CioAcq),
        .ChSel      (ChSel),
        .Mode       (Mode),
        .state      (state),
        .HaltReason (HaltReason),
        .Iret       (Iret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle; outputs are sampled at the negedge and the IP-line model advances here.
    task automatic tick();
        @(negedge Clk);
        IpReady = 1'b0;
        if (ip_pend) begin
            IpReady   = 1'b1;
            IpAddress = 24'(pc);
            Insn      = rom[pc];
            pc++;
            ip_pend   = 1'b0;
        end
        if (IpRequest === 1'b1) begin
            ip_pend = 1'b1;
            req_cnt++;
        end
        if (DataRequest === 1'b1) begin
            dreq_cnt++;
            dec_seen = Dec;
        end
        if (ApRequest === 1'b1) apreq_cnt++;
        if (CinReq !== 2'b00) cinreq_cyc++;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (state === st) else begin
            n_fail++;
            $error("FAIL %s: state %0d after %0d cycles, expected %0d", tag, state, n, st);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        Halt = 1'b0; Step = 1'b0; Run = 1'b0; BrkEn = 1'b0; CioAcq = 2'b00;
        DataZero = 1'b0; ApZero = 1'b0; ApReady = 1'b1;
        IpReady = 1'b0; ip_pend = 1'b0; pc = 0;
        req_cnt = 0; dreq_cnt = 0; apreq_cnt = 0; cinreq_cyc = 0; dec_seen = 1'b0;
        foreach (rom[i]) rom[i] = 4'h0;
        tick();
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic press_run();
        Run = 1'b1;
        tick();
        Run = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_state", 32'(state), 32'd4);
        check("rst_mode", 32'(Mode), 32'd1);
        check("rst_chsel", 32'(ChSel), 32'd0);
        check("rst_iret", Iret, 32'd0);
        check("rst_reason", 32'(HaltReason), 32'd0);
        check("rst_strobes", {26'd0, IpRequest, DataRequest, Cout, CinReq}, 32'd0);

        // "+ + HALT"
        rom[0] = 4'h2; rom[1] = 4'h2; rom[2] = 4'h1;
        press_run();
        check("run_idle", 32'(state), 32'd1);
        wait_state(3'd4, 60, "pp_halt");
        check("pp_reason", 32'(HaltReason), 32'd3);
        check("pp_iret", Iret, 32'd2);
        check("pp_dreq", 32'(dreq_cnt), 32'd2);
        check("pp_dec", 32'(dec_seen), 32'd0);
        check("pp_ipreq", 32'(req_cnt), 32'd3);

        // "- < HALT": Dec follows Insn[0] and is held after the decode
        do_reset();
        rom[0] = 4'h3; rom[1] = 4'h5; rom[2] = 4'h1;
        press_run();
        wait_state(3'd4, 60, "mm_halt");
        check("mm_dec_pulse", 32'(dec_seen), 32'd1);
        check("mm_apreq", 32'(apreq_cnt), 32'd1);
        check("mm_dec_held", 32'(Dec), 32'd1);
        check("mm_iret", Iret, 32'd2);

        // Step over NOPs: 3 retires, then StepCount=0 gives 1
        do_reset();
        StepCount = 8'd3;
        Step = 1'b1; tick(); Step = 1'b0;
        wait_state(3'd4, 80, "step3_halt");
        check("step3_reason", 32'(HaltReason), 32'd2);
        check("step3_iret", Iret, 32'd3);
        StepCount = 8'd0;
        Step = 1'b1; tick(); Step = 1'b0;
        wait_state(3'd4, 80, "step0_halt");
        check("step0_reason", 32'(HaltReason), 32'd2);
        check("step0_iret", Iret, 32'd4);

        // Halt held while running stops at the first retire
        Halt = 1'b1;
        press_run();
        wait_state(3'd4, 80, "halt_in");
        Halt = 1'b0;
        check("halt_reason", 32'(HaltReason), 32'd1);
        check("halt_iret", Iret, 32'd5);

        // Breakpoint at address 5, then resume from it without re-trigger
        do_reset();
        rom[6] = 4'h1;
        BrkEn = 1'b1; BrkAddr = 24'd5;
        press_run();
        wait_state(3'd4, 100, "brk_halt");
        check("brk_reason", 32'(HaltReason), 32'd4);
        check("brk_iret", Iret, 32'd5);
        pc = 5;
        press_run();
        wait_state(3'd4, 100, "brk_resume");
        check("brk_resume_reason", 32'(HaltReason), 32'd3);
        check("brk_resume_iret", Iret, 32'd6);
        BrkEn = 1'b0;

        // Debug-mode channel switch, then COUT on channel 1
        do_reset();
        rom[0] = 4'hE; rom[1] = 4'hC; rom[2] = 4'hF; rom[3] = 4'h8; rom[4] = 4'h1;
        press_run();
        wait_state(3'd6, 80, "cout_enter");
        check("cout_strobe", 32'(Cout), 32'd2);
        check("cout_chsel", 32'(ChSel), 32'd1);
        CioAcq = 2'b01;
        tick(); tick(); tick();
        check("cout_wrong_ack_state", 32'(state), 32'd6);
        check("cout_wrong_ack_strobe", 32'(Cout), 32'd2);
        CioAcq = 2'b10;
        tick();
        CioAcq = 2'b00;
        check("cout_ack_drop", 32'(Cout), 32'd0);
        check("cout_ack_exec", 32'(state), 32'd3);
        wait_state(3'd4, 40, "cout_halt");
        check("cout_iret", Iret, 32'd4);
        check("cout_mode", 32'(Mode), 32'd1);

        // CIN acked on channel 0; the other channel's ack is ignored
        do_reset();
        rom[0] = 4'h9; rom[1] = 4'h1;
        press_run();
        wait_state(3'd5, 40, "cin_enter");
        CioAcq = 2'b10;
        tick();
        check("cin_wrong_ack", {30'd0, CinReq}, 32'd1);
        CioAcq = 2'b01;
        tick();
        CioAcq = 2'b00;
        check("cin_ack_pulse", {29'd0, Cin, DataRequest, CinReq == 2'b00}, 32'd7);
        wait_state(3'd4, 40, "cin_halt");
        check("cin_iret", Iret, 32'd1);

        // CIN timeout
        do_reset();
        rom[0] = 4'h9;
        press_run();
        wait_state(3'd4, 60, "to_halt");
        check("to_cycles", 32'(cinreq_cyc), 32'd10);
        check("to_reason", 32'(HaltReason), 32'd5);
        check("to_iret", Iret, 32'd0);
        check("to_strobe", {30'd0, CinReq}, 32'd0);

        // Loop skip on DataZero (ApZero deliberately disagrees)
        do_reset();
        rom[0] = 4'h6; rom[1] = 4'h7; rom[2] = 4'h1;
        DataZero = 1'b1; ApZero = 1'b0;
        press_run();
        wait_state(3'd4, 60, "loop_halt");
        check("loop_ipreq", 32'(req_cnt), 32'd3);
        check("loop_iret", Iret, 32'd1);
        check("loop_reason", 32'(HaltReason), 32'd3);

        // Asynchronous reset while COUT is held
        do_reset();
        rom[0] = 4'h8;
        press_run();
        wait_state(3'd6, 40, "arst_cout");
        check("arst_pre", 32'(Cout), 32'd1);
        #1 Rst_n = 1'b0;
        #1;
        check("arst_cout_drop", 32'(Cout), 32'd0);
        check("arst_state", 32'(state), 32'd4);
        tick();
        Rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
